// File: rtl/serializer_pkg.sv
// Shared types and default sizing for the word serializer controller.
package serializer_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} ser_state_t;

  localparam int SER_WIDTH    = 16;
  localparam int SER_TICK_DIV = 4;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts clocks while enabled, flags the last clock of each bit.
module bit_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  assign tick = enable && (tick_cnt == TERM);

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_serializer_ctrl.sv
// Accepts a word, loads the external shift register, and streams it LSB-first
// on Ser_Out with each bit held TICK_DIV clocks; optional rotate-back loopback.
//
// state   | meaning
// S_IDLE  | ready for a new word
// S_LOAD  | Load strobe to the shift register
// S_SHIFT | serial output, one Shift_En per bit period
// S_DONE  | one-cycle Done pulse, counters cleared
module word_serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int WIDTH    = SER_WIDTH,
  parameter int TICK_DIV = SER_TICK_DIV
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Data,
  output logic             In_Ready,
  input  logic             Loop,
  output logic [WIDTH-1:0] D,
  output logic             Load,
  output logic             Shift_En,
  output logic             Shift_In,
  input  logic             Shift_Out,
  output logic             Ser_Out,
  output logic             Ser_Valid,
  output logic             Done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t    state;
  logic [BW-1:0] bit_cnt;
  logic          loop_q;
  logic          tick;
  logic          in_shift;

  assign in_shift = (state == S_SHIFT);

  bit_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (!in_shift),
    .enable (in_shift),
    .tick   (tick)
  );

  assign Shift_En = tick;
  assign Ser_Out  = in_shift ? Shift_Out : 1'b1;
  assign Shift_In = loop_q & Shift_Out;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      D         <= '0;
      loop_q    <= 1'b0;
      bit_cnt   <= '0;
      In_Ready  <= 1'b0;
      Load      <= 1'b0;
      Ser_Valid <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Load <= 1'b0;
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (In_Valid && In_Ready) begin
            D        <= In_Data;
            loop_q   <= Loop;
            Load     <= 1'b1;
            In_Ready <= 1'b0;
            state    <= S_LOAD;
          end else begin
            In_Ready <= 1'b1;
          end
        end
        S_LOAD: begin
          Ser_Valid <= 1'b1;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              Ser_Valid <= 1'b0;
              Done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          bit_cnt  <= '0;
          In_Ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          bit_cnt   <= '0;
          Ser_Valid <= 1'b0;
          In_Ready  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
